// File: rtl/fc1_layer_sequencer.sv
// Sequencer for the FC1 layer: streams weights/biases from ROM once per reset, then buffers
// 48-activation frames and issues them as 3-lane beats, waiting for each frame's result.
module fc1_layer_sequencer #(
    parameter int unsigned INPUT_NUM   = 48,
    parameter int unsigned OUTPUT_NUM  = 16,
    parameter int unsigned LANES       = 3,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned OUT_TIMEOUT = 64
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    output logic                rom_rd,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [7:0]          rom_data,
    output logic                fc_weight_valid,
    output logic [7:0]          fc_filter,
    input  logic                fc_weight_done,
    input  logic                act_valid,
    input  logic signed [15:0]  act_data,
    output logic                act_ready,
    output logic                fc_i_valid,
    output logic signed [15:0]  fc_data_1,
    output logic signed [15:0]  fc_data_2,
    output logic signed [15:0]  fc_data_3,
    input  logic                fc_o_valid,
    output logic                frame_done,
    output logic                busy,
    output logic                err_timeout
);

    localparam int unsigned W_TOTAL = INPUT_NUM * OUTPUT_NUM + OUTPUT_NUM;
    localparam int unsigned BEATS   = INPUT_NUM / LANES;
    localparam int unsigned WR_W    = $clog2(INPUT_NUM + 1);
    localparam int unsigned BEAT_W  = $clog2(BEATS);
    localparam int unsigned TMR_W   = $clog2(OUT_TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StWaitWd,
        StCollect,
        StIssue,
        StWaitOut
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [ADDR_W-1:0]   r_rd_cnt;
    logic [WR_W-1:0]     r_wr_cnt;
    logic [BEAT_W-1:0]   r_beat;
    logic [TMR_W-1:0]    r_timer;
    logic                r_flag;
    logic                r_err;
    logic                r_rd_d1;
    logic                r_wv;
    logic [7:0]          r_filter;
    logic signed [15:0]  r_buf [INPUT_NUM];
    logic                w_accept;
    logic                w_timeout;
    logic [WR_W-1:0]     w_base;

    always_comb begin
        w_state_next = r_state;
        rom_rd       = 1'b0;
        act_ready    = 1'b0;
        fc_i_valid   = 1'b0;
        frame_done   = 1'b0;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_start) w_state_next = StLoadW;
            end
            StLoadW: begin
                rom_rd = 1'b1;
                if (r_rd_cnt == ADDR_W'(W_TOTAL - 1)) w_state_next = StWaitWd;
            end
            StWaitWd: begin
                if (fc_weight_done) w_state_next = StCollect;
            end
            StCollect: begin
                act_ready = (r_wr_cnt < WR_W'(INPUT_NUM));
                w_accept  = act_ready && act_valid;
                if (w_accept && (r_wr_cnt == WR_W'(INPUT_NUM - 1))) w_state_next = StIssue;
            end
            StIssue: begin
                fc_i_valid = 1'b1;
                if (r_beat == BEAT_W'(BEATS - 1)) w_state_next = StWaitOut;
            end
            StWaitOut: begin
                // A result that arrived in time wins over a coincident timeout.
                if (r_flag) begin
                    frame_done   = 1'b1;
                    w_state_next = StCollect;
                end else if (r_timer == TMR_W'(OUT_TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = StCollect;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_base    = WR_W'(r_beat) * WR_W'(LANES);
        rom_addr  = rom_rd ? r_rd_cnt : '0;
        fc_data_1 = fc_i_valid ? r_buf[w_base] : '0;
        fc_data_2 = fc_i_valid ? r_buf[w_base + WR_W'(1)] : '0;
        fc_data_3 = fc_i_valid ? r_buf[w_base + WR_W'(2)] : '0;
    end

    assign busy            = (r_state != StIdle);
    assign fc_weight_valid = r_wv;
    assign fc_filter       = r_filter;
    assign err_timeout     = r_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state  <= StIdle;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_beat   <= '0;
            r_timer  <= '0;
            r_flag   <= 1'b0;
            r_err    <= 1'b0;
            r_rd_d1  <= 1'b0;
            r_wv     <= 1'b0;
            r_filter <= '0;
        end else begin
            r_state <= w_state_next;
            // ROM answers one cycle after the read; one more stage keeps strobe and byte aligned.
            r_rd_d1  <= rom_rd;
            r_wv     <= r_rd_d1;
            r_filter <= r_rd_d1 ? rom_data : '0;
            if (r_state == StIdle) begin
                r_rd_cnt <= '0;
            end else if (rom_rd) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_accept) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end else if (r_state == StWaitOut && w_state_next == StCollect) begin
                r_wr_cnt <= '0;
            end
            r_beat  <= (r_state == StIssue) ? r_beat + 1'b1 : '0;
            r_timer <= (r_state == StWaitOut) ? r_timer + 1'b1 : '0;
            if (w_state_next == StIssue && r_state != StIssue) begin
                r_flag <= 1'b0;
            end else if (fc_o_valid && (r_state == StIssue || r_state == StWaitOut)) begin
                r_flag <= 1'b1;
            end
            if (w_timeout) r_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) r_buf[r_wr_cnt] <= act_data;
    end

endmodule
